sdram_port_arbiter: RTL and testbench
=====================================

# sdram_port_arbiter

Shares the single FPGA-to-HPS SDRAM Avalon-MM port between the frame writer (write-only master) and the frame reader (read-only master) in the `sdram_clk` domain. It grants bursts to one master at a time with a fairness quantum and a reader-urgency override. It also tracks in-flight reads so the return path never exceeds a fixed outstanding limit. It sits between both masters and the SDRAM port; read data always returns to the reader.

## Interface
- `DATA_WIDTH`, default 64: Avalon data width.
- `RD_QUANTUM`, default 16: maximum consecutive read commands per grant when the writer is waiting.
- `WR_QUANTUM`, default 4: maximum consecutive write bursts per grant when the reader is waiting.
- `MAX_OUTSTANDING`, default 32: maximum in-flight read beats.
- `sdram_clk` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `rd_address_i` in 27, `rd_burstcount_i` in 8, `rd_read_i` in 1: reader command.
- `rd_urgent_i` in 1: reader FIFO is below its headroom, so the reader gets priority.
- `rd_waitrequest_o` out 1, `rd_readdata_o` out DATA_WIDTH, `rd_readdatavalid_o` out 1: reader response.
- `wr_address_i` in 27, `wr_burstcount_i` in 8, `wr_write_i` in 1, `wr_writedata_i` in DATA_WIDTH, `wr_byteenable_i` in DATA_WIDTH/8: writer command.
- `wr_waitrequest_o` out 1: writer stall.
- `sdram_address_o` out 27, `sdram_burstcount_o` out 8, `sdram_read_o` out 1, `sdram_write_o` out 1, `sdram_writedata_o` out DATA_WIDTH, `sdram_byteenable_o` out DATA_WIDTH/8: SDRAM command.
- `sdram_waitrequest_i` in 1, `sdram_readdata_i` in DATA_WIDTH, `sdram_readdatavalid_i` in 1: SDRAM response.
- `outstanding_o` out $clog2(MAX_OUTSTANDING)+1: current in-flight read beats, for debug.

## Operation
- The FSM has three states: IDLE, RD_GRANT and WR_GRANT.
- In IDLE, the arbiter selects one master:
  - If both masters request, the reader wins if `rd_urgent_i` is high, or if the last grant was WR_GRANT.
  - Otherwise the writer wins.
  - A single requester always wins.
  - With no request, the FSM stays in IDLE.
- The command mux is combinational from the granted master. The ungranted master sees waitrequest=1. In IDLE, all `sdram_read_o`/`sdram_write_o` are 0 and both waitrequests are 1.
- RD_GRANT:
  - A read is forwarded only if `outstanding + rd_burstcount_i <= MAX_OUTSTANDING`. Otherwise `sdram_read_o`=0 and `rd_waitrequest_o`=1.
  - An accepted read is `sdram_read_o & ~sdram_waitrequest_i`. It increments the quantum counter and adds the burstcount to `outstanding`.
  - Exit to IDLE when `rd_read_i`=0, or when the quantum counter reaches RD_QUANTUM while `wr_write_i`=1.
- WR_GRANT:
  - The grant is locked until every beat of the current burst is accepted. The beat counter loads `wr_burstcount_i` on the first accepted beat.
  - At the burst boundary, exit to IDLE when `wr_write_i`=0, when WR_QUANTUM bursts are done while `rd_read_i`=1, or immediately when `rd_urgent_i`=1 and `rd_read_i`=1.
  - Exit never occurs mid-burst.
- `outstanding` decrements by 1 on each `sdram_readdatavalid_i`.
  - If an accepted read and a valid beat land in the same cycle, the net change is burstcount-1.
  - `outstanding` never underflows. A valid beat at 0 holds the count at 0 and sets a sticky internal error bit.
- `rd_readdata_o`/`rd_readdatavalid_o` pass through combinationally in every state.
- Burstcount 0 is treated as 1.

## Timing
- Reset values: state=IDLE, outstanding=0, counters=0, last grant=WR. All SDRAM command outputs are 0. Both waitrequests are 1.
- Grant latency is 1 cycle: the request is seen in IDLE, and the command is forwarded in the next cycle in RD_GRANT/WR_GRANT.
- Re-arbitration costs exactly one IDLE cycle between grants.
- The command path adds no pipeline register (address/data/control are combinational). The waitrequest path is combinational.
- Masters must hold their command stable while waitrequest=1. The arbiter never changes grant while a forwarded command is stalled.
- Reset mid-burst or with reads outstanding: the FSM returns to IDLE next cycle and `outstanding` clears. Any late readdatavalid beats still pass to the reader.

## Structure
- The package `sdram_arb_pkg` holds:
  - the state enum `arb_state_t` {IDLE, RD_GRANT, WR_GRANT};
  - the grant enum `grant_t` {GNT_RD, GNT_WR};
  - the address width 27 and burstcount width 8 as localparams.
- One sub-module, `rd_outstanding_tracker`: the outstanding counter with limit check (inputs: accept, burstcount, valid; outputs: count, can_issue, error).

## Test plan
- Reader only, 40 single-beat reads, MAX_OUTSTANDING=32, no readdatavalid returned → exactly 32 reads are forwarded, then `rd_waitrequest_o`=1. Each returned beat releases exactly one more read.
- Both masters continuously requesting, no urgency, burstcount=8 writes → the grant alternates: 4 write bursts (32 beats) / 16 reads, with one IDLE cycle between grants.
- Writer mid-burst at beat 3 of 8 when `rd_urgent_i` rises → the writer completes all 8 beats, then IDLE, then RD_GRANT. There is no interleaved read.
- `sdram_waitrequest_i` held high for 5 cycles during a read → address and read stay stable, the grant does not change, and `outstanding` increments only once.
- Accepted read of burstcount 4 in the same cycle as a readdatavalid, with outstanding=10 → outstanding becomes 13.
- Assert `rst` with outstanding=7 and WR_GRANT mid-burst → next cycle state=IDLE, outstanding=0, all SDRAM commands 0, both waitrequests 1.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM port arbiter.
// Pure declarations: no latency and no flow control of its own.
package sdram_arb_pkg;

    localparam int ADDR_W  = 27;
    localparam int BURST_W = 8;

    typedef enum logic [1:0] {IDLE, RD_GRANT, WR_GRANT} arb_state_t;
    typedef enum logic {GNT_RD, GNT_WR} grant_t;

    // A burstcount of zero is treated as a single beat everywhere.
    function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
        return (bc == '0) ? BURST_W'(1) : bc;
    endfunction

endpackage

// File: rtl/rd_outstanding_tracker.sv
// Counts in-flight read beats and tells the arbiter whether the next read fits under the limit.
// Count updates one cycle after accept/valid; can_issue is combinational; never stalls anything itself.
module rd_outstanding_tracker
    import sdram_arb_pkg::*;
#(
    parameter  int MAX_OUTSTANDING = 32,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic               sdram_clk,
    input  logic               rst,
    input  logic               accept,
    input  logic [BURST_W-1:0] burstcount,
    input  logic               valid,
    output logic [CNT_W-1:0]   count,
    output logic               can_issue,
    output logic               error
);

    logic [BURST_W-1:0] eff_bc;
    logic [31:0]        sum;
    logic [31:0]        added;
    logic [31:0]        nxt;
    logic               underflow;

    always_comb begin
        eff_bc    = eff_burst(burstcount);
        sum       = 32'(count) + 32'(eff_bc);
        can_issue = (sum <= 32'(MAX_OUTSTANDING));
        added     = accept ? sum : 32'(count);
        // A beat with nothing in flight is a protocol error: clamp rather than wrap.
        underflow = valid && (added == 32'd0);
        nxt       = (valid && !underflow) ? added - 32'd1 : added;
    end

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            count <= '0;
            error <= 1'b0;
        end else begin
            count <= CNT_W'(nxt);
            if (underflow) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-MM SDRAM port between a read-only and a write-only master with quantum fairness.
// Grant takes one IDLE cycle; command/waitrequest paths are combinational; losers see waitrequest=1.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter  int DATA_WIDTH      = 64,
    parameter  int RD_QUANTUM      = 16,
    parameter  int WR_QUANTUM      = 4,
    parameter  int MAX_OUTSTANDING = 32,
    localparam int CNT_W           = $clog2(MAX_OUTSTANDING) + 1,
    localparam int BE_W            = DATA_WIDTH / 8
) (
    input  logic                  sdram_clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rd_address_i,
    input  logic [BURST_W-1:0]    rd_burstcount_i,
    input  logic                  rd_read_i,
    input  logic                  rd_urgent_i,
    output logic                  rd_waitrequest_o,
    output logic [DATA_WIDTH-1:0] rd_readdata_o,
    output logic                  rd_readdatavalid_o,
    input  logic [ADDR_W-1:0]     wr_address_i,
    input  logic [BURST_W-1:0]    wr_burstcount_i,
    input  logic                  wr_write_i,
    input  logic [DATA_WIDTH-1:0] wr_writedata_i,
    input  logic [BE_W-1:0]       wr_byteenable_i,
    output logic                  wr_waitrequest_o,
    output logic [ADDR_W-1:0]     sdram_address_o,
    output logic [BURST_W-1:0]    sdram_burstcount_o,
    output logic                  sdram_read_o,
    output logic                  sdram_write_o,
    output logic [DATA_WIDTH-1:0] sdram_writedata_o,
    output logic [BE_W-1:0]       sdram_byteenable_o,
    input  logic                  sdram_waitrequest_i,
    input  logic [DATA_WIDTH-1:0] sdram_readdata_i,
    input  logic                  sdram_readdatavalid_i,
    output logic [CNT_W-1:0]      outstanding_o
);

    localparam int QMAX = (RD_QUANTUM > WR_QUANTUM) ? RD_QUANTUM : WR_QUANTUM;
    localparam int QW   = $clog2(QMAX + 1);
    localparam logic [QW-1:0] RD_Q  = QW'(RD_QUANTUM);
    localparam logic [QW-1:0] WR_Q  = QW'(WR_QUANTUM);
    localparam logic [QW-1:0] Q_SAT = '1;

    arb_state_t         state, state_nxt;
    grant_t             last_gnt, last_nxt;
    logic [QW-1:0]      q_cnt, q_nxt;
    logic               in_burst, in_burst_nxt;
    logic [BURST_W-1:0] beats_left, beats_nxt;
    logic [BURST_W-1:0] wr_bc_eff;
    logic               rd_fwd, wr_fwd, rd_acc, wr_acc, burst_end;
    logic               can_issue;
    logic               trk_err_unused;

    assign wr_bc_eff          = eff_burst(wr_burstcount_i);
    assign rd_readdata_o      = sdram_readdata_i;
    assign rd_readdatavalid_o = sdram_readdatavalid_i;

    rd_outstanding_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tracker (
        .sdram_clk  (sdram_clk),
        .rst        (rst),
        .accept     (rd_acc),
        .burstcount (rd_burstcount_i),
        .valid      (sdram_readdatavalid_i),
        .count      (outstanding_o),
        .can_issue  (can_issue),
        .error      (trk_err_unused)
    );

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state      <= IDLE;
            last_gnt   <= GNT_WR;
            q_cnt      <= '0;
            in_burst   <= 1'b0;
            beats_left <= '0;
        end else begin
            state      <= state_nxt;
            last_gnt   <= last_nxt;
            q_cnt      <= q_nxt;
            in_burst   <= in_burst_nxt;
            beats_left <= beats_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last_gnt;
        q_nxt        = q_cnt;
        in_burst_nxt = in_burst;
        beats_nxt    = beats_left;
        rd_fwd       = 1'b0;
        wr_fwd       = 1'b0;
        rd_acc       = 1'b0;
        wr_acc       = 1'b0;
        burst_end    = 1'b0;
        case (state)
            IDLE: begin
                q_nxt        = '0;
                in_burst_nxt = 1'b0;
                beats_nxt    = '0;
                if (rd_read_i && (!wr_write_i || rd_urgent_i || last_gnt == GNT_WR)) begin
                    state_nxt = RD_GRANT;
                    last_nxt  = GNT_RD;
                end else if (wr_write_i) begin
                    state_nxt = WR_GRANT;
                    last_nxt  = GNT_WR;
                end
            end
            RD_GRANT: begin
                rd_fwd = rd_read_i && can_issue;
                rd_acc = rd_fwd && !sdram_waitrequest_i;
                if (rd_acc && q_cnt != Q_SAT) begin
                    q_nxt = q_cnt + QW'(1);
                end
                // A stalled forwarded read keeps the grant even once the quantum is spent.
                if (!rd_read_i ||
                    (q_nxt >= RD_Q && wr_write_i && !(rd_fwd && sdram_waitrequest_i))) begin
                    state_nxt = IDLE;
                end
            end
            WR_GRANT: begin
                wr_fwd = wr_write_i;
                wr_acc = wr_fwd && !sdram_waitrequest_i;
                if (wr_acc) begin
                    if (in_burst) begin
                        burst_end = (beats_left == BURST_W'(1));
                        beats_nxt = beats_left - BURST_W'(1);
                    end else begin
                        burst_end = (wr_bc_eff == BURST_W'(1));
                        beats_nxt = wr_bc_eff - BURST_W'(1);
                    end
                    in_burst_nxt = !burst_end;
                end
                if (burst_end && q_cnt != Q_SAT) begin
                    q_nxt = q_cnt + QW'(1);
                end
                if (burst_end && rd_read_i && (rd_urgent_i || q_nxt >= WR_Q)) begin
                    state_nxt = IDLE;
                end else if (!in_burst && !wr_write_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sdram_read_o       = rd_fwd;
        sdram_write_o      = wr_fwd;
        rd_waitrequest_o   = !rd_acc;
        wr_waitrequest_o   = !wr_acc;
        sdram_address_o    = '0;
        sdram_burstcount_o = '0;
        sdram_writedata_o  = '0;
        sdram_byteenable_o = '0;
        case (state)
            RD_GRANT: begin
                sdram_address_o    = rd_address_i;
                sdram_burstcount_o = eff_burst(rd_burstcount_i);
            end
            WR_GRANT: begin
                sdram_address_o    = wr_address_i;
                sdram_burstcount_o = wr_bc_eff;
                sdram_writedata_o  = wr_writedata_i;
                sdram_byteenable_o = wr_byteenable_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: arbitration table, directed corner sequences, randomized traffic vs a transaction model.
module tb_sdram_port_arbiter;

    logic        sdram_clk = 1'b0;
    logic        rst;
    logic [26:0] rd_address_i;
    logic [7:0]  rd_burstcount_i;
    logic        rd_read_i, rd_urgent_i;
    logic        rd_waitrequest_o;
    logic [63:0] rd_readdata_o;
    logic        rd_readdatavalid_o;
    logic [26:0] wr_address_i;
    logic [7:0]  wr_burstcount_i;
    logic        wr_write_i;
    logic [63:0] wr_writedata_i;
    logic [7:0]  wr_byteenable_i;
    logic        wr_waitrequest_o;
    logic [26:0] sdram_address_o;
    logic [7:0]  sdram_burstcount_o;
    logic        sdram_read_o, sdram_write_o;
    logic [63:0] sdram_writedata_o;
    logic [7:0]  sdram_byteenable_o;
    logic        sdram_waitrequest_i;
    logic [63:0] sdram_readdata_i;
    logic        sdram_readdatavalid_i;
    logic [5:0]  outstanding_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdram_port_arbiter #(
        .DATA_WIDTH(64), .RD_QUANTUM(16), .WR_QUANTUM(4), .MAX_OUTSTANDING(32)
    ) dut (
        .sdram_clk(sdram_clk), .rst(rst),
        .rd_address_i(rd_address_i), .rd_burstcount_i(rd_burstcount_i),
        .rd_read_i(rd_read_i), .rd_urgent_i(rd_urgent_i),
        .rd_waitrequest_o(rd_waitrequest_o), .rd_readdata_o(rd_readdata_o),
        .rd_readdatavalid_o(rd_readdatavalid_o),
        .wr_address_i(wr_address_i), .wr_burstcount_i(wr_burstcount_i),
        .wr_write_i(wr_write_i), .wr_writedata_i(wr_writedata_i),
        .wr_byteenable_i(wr_byteenable_i), .wr_waitrequest_o(wr_waitrequest_o),
        .sdram_address_o(sdram_address_o), .sdram_burstcount_o(sdram_burstcount_o),
        .sdram_read_o(sdram_read_o), .sdram_write_o(sdram_write_o),
        .sdram_writedata_o(sdram_writedata_o), .sdram_byteenable_o(sdram_byteenable_o),
        .sdram_waitrequest_i(sdram_waitrequest_i), .sdram_readdata_i(sdram_readdata_i),
        .sdram_readdatavalid_i(sdram_readdatavalid_i), .outstanding_o(outstanding_o)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic clear_inputs();
        rd_address_i = '0; rd_burstcount_i = 8'd1; rd_read_i = 1'b0; rd_urgent_i = 1'b0;
        wr_address_i = '0; wr_burstcount_i = 8'd8; wr_write_i = 1'b0;
        wr_writedata_i = '0; wr_byteenable_i = '0;
        sdram_waitrequest_i = 1'b0; sdram_readdata_i = '0; sdram_readdatavalid_i = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Which command actually crossed to the SDRAM this cycle.
    function automatic byte lbl();
        if (sdram_read_o && !sdram_waitrequest_i) return "R";
        if (sdram_write_o && !sdram_waitrequest_i) return "W";
        return "I";
    endfunction

    // Continuous contention: 1 IDLE, 16 reads, 1 IDLE, 4x8 write beats, repeating.
    function automatic byte exp_alt(input int c);
        int p;
        p = c % 50;
        if (p == 0 || p == 17) return "I";
        if (p <= 16) return "R";
        return "W";
    endfunction

    typedef struct {
        bit last_rd;
        bit rd;
        bit urg;
        bit wr;
        bit exp_rd;
        bit exp_wr;
    } arb_vec_t;

    arb_vec_t vecs[8];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int     n, first_bad, pend, wr_left, stall_run, max_stall;
        bit     rd_stalled, wr_stalled, ok;
        logic [7:0] eff_rd, eff_wr;
        string  exp_c;

        vecs[0] = '{0, 1, 0, 0, 1, 0};
        vecs[1] = '{0, 0, 0, 1, 0, 1};
        vecs[2] = '{0, 1, 0, 1, 1, 0};
        vecs[3] = '{1, 1, 0, 1, 0, 1};
        vecs[4] = '{1, 1, 1, 1, 1, 0};
        vecs[5] = '{0, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 1, 0, 0, 1, 0};
        vecs[7] = '{0, 0, 1, 1, 0, 1};

        rst = 1'b1;
        clear_inputs();
        tick();
        @(negedge sdram_clk);
        chk("reset outputs", 128'({sdram_read_o, sdram_write_o, rd_waitrequest_o, wr_waitrequest_o,
             sdram_address_o, sdram_burstcount_o, sdram_writedata_o, sdram_byteenable_o, outstanding_o}),
            128'({1'b0, 1'b0, 1'b1, 1'b1, 27'd0, 8'd0, 64'd0, 8'd0, 6'd0}));

        // IDLE arbitration table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].last_rd) begin
                rd_read_i = 1'b1;
                tick();
                tick();
                rd_read_i = 1'b0;
                tick();
            end
            rd_read_i = vecs[i].rd; rd_urgent_i = vecs[i].urg; wr_write_i = vecs[i].wr;
            @(negedge sdram_clk);
            chk($sformatf("arb%0d idle", i),
                128'({sdram_read_o, sdram_write_o, rd_waitrequest_o, wr_waitrequest_o}), 128'(4'b0011));
            tick();
            @(negedge sdram_clk);
            chk($sformatf("arb%0d grant", i), 128'({sdram_read_o, sdram_write_o}),
                128'({vecs[i].exp_rd, vecs[i].exp_wr}));
        end

        // Outstanding limit with no returned data
        do_reset();
        rd_read_i = 1'b1; rd_burstcount_i = 8'd1;
        n = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge sdram_clk);
            if (lbl() == "R") n++;
            tick();
        end
        chk("limit reads forwarded", 128'(n), 128'(32));
        @(negedge sdram_clk);
        chk("limit waitrequest", 128'({rd_waitrequest_o, sdram_read_o}), 128'(2'b10));
        chk("limit outstanding", 128'(outstanding_o), 128'(32));
        tick();
        sdram_readdatavalid_i = 1'b1;
        tick();
        sdram_readdatavalid_i = 1'b0;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sdram_clk);
            if (lbl() == "R") n++;
            tick();
        end
        chk("one beat releases one read", 128'(n), 128'(1));

        // Both masters saturating: quantum alternation
        do_reset();
        rd_read_i = 1'b1; wr_write_i = 1'b1; wr_burstcount_i = 8'd8;
        pend = 0; first_bad = 0;
        for (int c = 0; c < 150; c++) begin
            sdram_readdatavalid_i = (pend > 0);
            @(negedge sdram_clk);
            if (lbl() != exp_alt(c) && first_bad == 0) first_bad = c + 1;
            if (lbl() == "R") pend++;
            if (sdram_readdatavalid_i) pend--;
            tick();
        end
        sdram_readdatavalid_i = 1'b0;
        chk("alternation first bad cycle+1", 128'(first_bad), 128'(0));

        // Urgency mid write burst: burst completes, then IDLE, then read
        do_reset();
        wr_write_i = 1'b1; wr_burstcount_i = 8'd8;
        exp_c = "IWWWWWWWWIR";
        first_bad = 0;
        for (int c = 0; c < 11; c++) begin
            if (c == 4) begin rd_read_i = 1'b1; rd_urgent_i = 1'b1; end
            @(negedge sdram_clk);
            if (lbl() != exp_c[c] && first_bad == 0) first_bad = c + 1;
            tick();
        end
        chk("urgent waits for burst end", 128'(first_bad), 128'(0));

        // SDRAM stall during a read: command held, counted once
        do_reset();
        rd_read_i = 1'b1; rd_address_i = 27'h1234567; rd_burstcount_i = 8'd4;
        wr_write_i = 1'b1; sdram_waitrequest_i = 1'b1;
        tick();
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sdram_clk);
            if ({sdram_read_o, sdram_write_o, sdram_address_o, sdram_burstcount_o, rd_waitrequest_o,
                 wr_waitrequest_o, outstanding_o} !== {1'b1, 1'b0, 27'h1234567, 8'd4, 1'b1, 1'b1, 6'd0})
                ok = 1'b0;
            tick();
        end
        chk("stall holds command", 128'(ok), 128'(1));
        sdram_waitrequest_i = 1'b0;
        @(negedge sdram_clk);
        chk("stall release accept", 128'({sdram_read_o, rd_waitrequest_o}), 128'(2'b10));
        tick();
        rd_read_i = 1'b0;
        @(negedge sdram_clk);
        chk("stall counted once", 128'(outstanding_o), 128'(4));

        // Accept and returned beat in the same cycle
        do_reset();
        rd_read_i = 1'b1; rd_burstcount_i = 8'd10;
        tick();
        tick();
        rd_burstcount_i = 8'd4; sdram_readdatavalid_i = 1'b1; sdram_readdata_i = 64'hDEAD_BEEF_0123_4567;
        @(negedge sdram_clk);
        chk("net start", 128'(outstanding_o), 128'(10));
        chk("readdata pass", 128'({rd_readdatavalid_o, rd_readdata_o}), 128'({1'b1, 64'hDEAD_BEEF_0123_4567}));
        tick();
        rd_read_i = 1'b0; sdram_readdatavalid_i = 1'b0;
        @(negedge sdram_clk);
        chk("net change bc-1", 128'(outstanding_o), 128'(13));

        // Reset mid write burst with reads outstanding
        do_reset();
        rd_read_i = 1'b1; rd_burstcount_i = 8'd7;
        tick();
        tick();
        rd_read_i = 1'b0; wr_write_i = 1'b1; wr_burstcount_i = 8'd8;
        wr_address_i = 27'h55AA; wr_writedata_i = 64'h1111_2222_3333_4444; wr_byteenable_i = 8'hF0;
        tick();
        tick();
        tick();
        tick();
        @(negedge sdram_clk);
        chk("pre-reset mid burst", 128'({sdram_write_o, outstanding_o}), 128'({1'b1, 6'd7}));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; sdram_readdatavalid_i = 1'b1; sdram_readdata_i = 64'h0BAD_F00D;
        @(negedge sdram_clk);
        chk("post-reset idle", 128'({sdram_read_o, sdram_write_o, rd_waitrequest_o, wr_waitrequest_o,
             sdram_address_o, sdram_writedata_o, sdram_byteenable_o, outstanding_o}),
            128'({1'b0, 1'b0, 1'b1, 1'b1, 27'd0, 64'd0, 8'd0, 6'd0}));
        chk("late beat passes", 128'({rd_readdatavalid_o, rd_readdata_o}), 128'({1'b1, 64'h0BAD_F00D}));
        tick();
        sdram_readdatavalid_i = 1'b0;
        @(negedge sdram_clk);
        chk("no underflow", 128'(outstanding_o), 128'(0));

        // Randomized traffic against a transaction-level model
        do_reset();
        pend = 0; wr_left = 0; rd_stalled = 1'b0; wr_stalled = 1'b0; stall_run = 0; max_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            sdram_readdatavalid_i = (pend > 0) && ($urandom_range(0, 1) == 1);
            sdram_readdata_i      = {$urandom, $urandom};
            sdram_waitrequest_i   = ($urandom_range(0, 3) == 0);
            rd_urgent_i           = ($urandom_range(0, 4) == 0);
            if (!(rd_read_i && rd_stalled)) begin
                rd_read_i       = ($urandom_range(0, 9) < 6);
                rd_burstcount_i = 8'($urandom_range(0, 6));
                rd_address_i    = 27'($urandom);
            end
            if (!(wr_write_i && wr_stalled)) begin
                if (wr_left > 0) begin
                    wr_write_i = ($urandom_range(0, 9) < 8);
                end else begin
                    wr_write_i      = ($urandom_range(0, 1) == 1);
                    wr_burstcount_i = 8'($urandom_range(0, 8));
                    wr_address_i    = 27'($urandom);
                end
                wr_writedata_i  = {$urandom, $urandom};
                wr_byteenable_i = 8'($urandom);
            end
            @(negedge sdram_clk);
            eff_rd = (rd_burstcount_i == 8'd0) ? 8'd1 : rd_burstcount_i;
            eff_wr = (wr_burstcount_i == 8'd0) ? 8'd1 : wr_burstcount_i;
            chk("rnd exclusive", 128'(sdram_read_o & sdram_write_o), 128'(0));
            chk("rnd outstanding", 128'(outstanding_o), 128'(pend));
            chk("rnd readdata pass", 128'({rd_readdatavalid_o, rd_readdata_o}),
                128'({sdram_readdatavalid_i, sdram_readdata_i}));
            chk("rnd rd wait", 128'(rd_waitrequest_o), 128'(!(sdram_read_o && !sdram_waitrequest_i)));
            chk("rnd wr wait", 128'(wr_waitrequest_o), 128'(!(sdram_write_o && !sdram_waitrequest_i)));
            if (sdram_read_o) begin
                chk("rnd rd cmd", 128'({sdram_address_o, sdram_burstcount_o}), 128'({rd_address_i, eff_rd}));
                chk("rnd rd within limit", 128'(pend + int'(eff_rd) <= 32), 128'(1));
                chk("rnd rd inside wr burst", 128'(wr_left), 128'(0));
            end
            if (sdram_write_o) begin
                chk("rnd wr cmd", 128'({sdram_address_o, sdram_burstcount_o, sdram_writedata_o, sdram_byteenable_o}),
                    128'({wr_address_i, eff_wr, wr_writedata_i, wr_byteenable_i}));
            end
            if (sdram_read_o && !sdram_waitrequest_i) pend += int'(eff_rd);
            if (sdram_readdatavalid_i) pend--;
            if (sdram_write_o && !sdram_waitrequest_i)
                wr_left = (wr_left == 0) ? int'(eff_wr) - 1 : wr_left - 1;
            rd_stalled = rd_read_i && rd_waitrequest_o;
            wr_stalled = wr_write_i && wr_waitrequest_o;
            stall_run  = rd_stalled ? stall_run + 1 : 0;
            if (stall_run > max_stall) max_stall = stall_run;
            tick();
        end
        chk("rnd reader not starved", 128'(max_stall < 400), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
